// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared BCD limits and active-low 7-segment codes
package seg7_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // {a,b,c,d,e,f,g,dp}, active-low, dp kept dark
  localparam logic [7:0] SEG7_0     = 8'b0000001_1;
  localparam logic [7:0] SEG7_1     = 8'b1001111_1;
  localparam logic [7:0] SEG7_2     = 8'b0010010_1;
  localparam logic [7:0] SEG7_3     = 8'b0000110_1;
  localparam logic [7:0] SEG7_4     = 8'b1001100_1;
  localparam logic [7:0] SEG7_5     = 8'b0100100_1;
  localparam logic [7:0] SEG7_6     = 8'b0100000_1;
  localparam logic [7:0] SEG7_7     = 8'b0001111_1;
  localparam logic [7:0] SEG7_8     = 8'b0000000_1;
  localparam logic [7:0] SEG7_9     = 8'b0000100_1;
  localparam logic [7:0] SEG7_BLANK = 8'b1111111_1;

  function automatic logic [7:0] seg7_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG7_0;
      4'd1:    return SEG7_1;
      4'd2:    return SEG7_2;
      4'd3:    return SEG7_3;
      4'd4:    return SEG7_4;
      4'd5:    return SEG7_5;
      4'd6:    return SEG7_6;
      4'd7:    return SEG7_7;
      4'd8:    return SEG7_8;
      4'd9:    return SEG7_9;
      default: return SEG7_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD decade with up/down step and carry/borrow out
module bcd_digit_cell
  import seg7_pkg::*;
(
  input  logic       dir,
  input  logic       sat,
  input  logic       term,
  input  logic       ci,
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o,
  output logic       co
);

  logic at_lim;

  // co reports a roll-over even when saturating, so the top cell's co doubles as the terminal flag
  always_comb begin
    at_lim  = dir ? (digit_i == BCD_MAX) : (digit_i == 4'd0);
    co      = ci && at_lim;
    digit_o = digit_i;
    if (ci && !(sat && term)) begin
      if (at_lim) digit_o = dir ? 4'd0 : BCD_MAX;
      else        digit_o = dir ? (digit_i + 4'd1) : (digit_i - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_counter_seg7_n.sv
// rtl/bcd_counter_seg7_n.sv - N-digit BCD up/down counter with prescaler and 7-segment scan
module bcd_counter_seg7_n
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  carry,
  output logic [DIGITS-1:0]     d_sel,
  output logic [7:0]            d_out
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [4*DIGITS-1:0] q_q, q_d, nxt;
  logic                carry_q, carry_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0]   d_sel_q, d_sel_d;
  logic [7:0]          d_out_q, d_out_d;
  logic [DIGITS:0]     chain;
  logic                tick, term, all9, all0, scan_end, higher_zero;
  logic [3:0]          nib;

  assign tick     = en && (div_cnt_q == DIV_LAST);
  assign chain[0] = tick;

  // terminal value for the current direction: all nines going up, all zeros going down
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q_q[i*4 +: 4] != BCD_MAX) all9 = 1'b0;
      if (q_q[i*4 +: 4] != 4'd0)    all0 = 1'b0;
    end
    term = dir ? all9 : all0;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cell
    bcd_digit_cell u_cell (
      .dir     (dir),
      .sat     (sat),
      .term    (term),
      .ci      (chain[gi]),
      .digit_i (q_q[gi*4 +: 4]),
      .digit_o (nxt[gi*4 +: 4]),
      .co      (chain[gi+1])
    );
  end

  // prescaler and count register; load beats tick and restarts the prescaler
  always_comb begin
    div_cnt_d = div_cnt_q;
    q_d       = q_q;
    carry_d   = 1'b0;
    if (load) begin
      div_cnt_d = '0;
      for (int i = 0; i < DIGITS; i++)
        q_d[i*4 +: 4] = (load_val[i*4 +: 4] > BCD_MAX) ? BCD_MAX : load_val[i*4 +: 4];
    end else begin
      if (en) div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) begin
        q_d     = nxt;
        carry_d = chain[DIGITS];
      end
    end
  end

  // scan slot timing and digit/segment data computed from the slot being entered
  always_comb begin
    scan_end   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_end ? '0 : scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_end) scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    nib         = 4'd0;
    higher_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx_d) nib = q_q[i*4 +: 4];
      if (IDX_W'(i) >= scan_idx_d && q_q[i*4 +: 4] != 4'd0) higher_zero = 1'b0;
    end
    d_sel_d = ~(DIGITS'(1) << scan_idx_d);
    d_out_d = (BLANK_LZ && scan_idx_d != '0 && higher_zero) ? SEG7_BLANK : seg7_encode(nib);
  end

  // all state registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      q_q        <= '0;
      carry_q    <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      d_sel_q    <= ~DIGITS'(1);
      d_out_q    <= SEG7_0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      q_q        <= q_d;
      carry_q    <= carry_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      d_sel_q    <= d_sel_d;
      d_out_q    <= d_out_d;
    end
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign d_sel = d_sel_q;
  assign d_out = d_out_q;

endmodule

// File: doc/bcd_counter_seg7_n.md
# bcd_counter_seg7_n

Parametrised N-digit BCD up/down counter with built-in prescaler and multiplexed 7-segment scan driver. It is the next-generation replacement for the fixed 2-digit up-counter display path. It adds the following over that path:
- configurable digit count
- count direction
- synchronous load
- wrap/saturate mode
- carry/borrow flag
- leading-zero blanking

It sits between the board clock and the 4-digit 7-segment display, and exposes the packed BCD value for other logic.

## Interface
- DIGITS, 4, number of BCD digits (1..8); also width of d_sel
- TICK_DIV, 25_000_000, clk cycles per count tick (>=2)
- SCAN_DIV, 100_000, clk cycles per display digit slot (>=1)
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked)

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-low reset
- en  input  1  1 = prescaler runs and ticks advance count
- dir  input  1  1 = count up, 0 = count down
- sat  input  1  0 = wrap at terminal value, 1 = saturate (hold)
- load  input  1  synchronous load strobe
- load_val  input  4*DIGITS  packed BCD value; nibble 0 = least significant digit
- q  output  4*DIGITS  current packed BCD count
- carry  output  1  one-cycle pulse on terminal-value tick
- d_sel  output  DIGITS  active-low one-hot digit enable; d_sel[0] = digit 0
- d_out  output  8  active-low segments; d_out[7:1] = a..g, d_out[0] = dp (always 1)

## Operation
**Prescaler**
- div_cnt counts 0..TICK_DIV-1 while en=1 and holds while en=0.
- tick=1 for one cycle when div_cnt==TICK_DIV-1 and en=1; div_cnt then returns to 0.

**Count register**

Priority is load > tick.
- **load:** q <= load_val, with each nibble >9 clamped to 9; div_cnt <= 0; no carry.
- **tick, dir=1:** BCD increment. At all-9s: wrap to 0 if sat=0, or hold if sat=1.
- **tick, dir=0:** BCD decrement. At 0: wrap to all-9s if sat=0, or hold if sat=1.
- **Digit behaviour:** each digit rolls 9->0 (up) or 0->9 (down) and propagates carry/borrow only to the next digit.
- **carry:** registered. It is 1 for the cycle after a tick applied at the terminal value (all-9s up, 0 down), in both sat modes.
- **dir/sat changes:** take effect on the next tick.

**Display scan**
- scan_cnt counts 0..SCAN_DIV-1; at the end of its count, scan_idx advances 0..DIGITS-1, then wraps to 0.
- Scan runs regardless of en.
- d_sel = ~(1<<scan_idx).
- d_out = segment code of nibble scan_idx of q. The nibble is shown blank (all 1s) when BLANK_LZ=1, scan_idx>0, and it and all higher nibbles are 0.

Segment codes (a..g, active-low):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100

## Timing
- **Reset (rst=0, asynchronous):**
  - q=0, carry=0, div_cnt=0, scan_cnt=0, scan_idx=0
  - d_sel = all 1s except bit 0
  - d_out = 0000001_1
- Reset deasserted mid-count or mid-scan restarts every counter from 0.
- q updates on the clk edge where tick or load is sampled; latency is 1 cycle.
- carry follows the q update by 0 cycles: it is registered alongside q and lasts 1 cycle.
- d_sel and d_out are registered, updating together on scan_idx change, so there is no glitch between digit and segment data.
- The new q is visible on the current digit slot at most 1 cycle later.

## Structure
- The shared package `seg7_pkg` holds:
  - segment code constants for 0..9
  - SEG7_BLANK = 8'b1111111_1
  - BCD_MAX = 4'd9
- Sub-module `bcd_digit_cell`: a one-decade cell (inputs dir, sat, ci; outputs next nibble, co).
  - Instantiate it DIGITS times with generate.
  - The top-level handles terminal detection, the prescaler and the scan.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4, SCAN_DIV=2, BLANK_LZ=1.

- **Reset:** rst low for 3 cycles, en=1 -> q=8'h00, carry=0, d_sel=2'b10, d_out=8'b0000001_1 throughout reset.
- **Up count with wrap:** load 8'h98, en=1, dir=1, sat=0 -> q=99 after 4 cycles, then 00 after 4 more; carry high exactly 1 cycle.
- **Down count with saturate:** load 8'h01, dir=0, sat=1 -> q=00, then q stays 00 on the next tick with a carry pulse, and q never becomes 99.
- **Load vs tick:** load 8'hA3 asserted on the tick cycle -> q=8'h93, div_cnt restarts, and the next change comes 4 cycles later.
- **Pause:** en=0 for 10 cycles mid-count -> q holds; scan still alternates d_sel 10/01 every 2 cycles.
- **Blanking:** q=8'h05 -> the digit-1 slot shows d_out=8'hFF and the digit-0 slot shows 8'b0100100_1.
